// File: rtl/kernel_call_pkg.sv
// Shared types for the kernel call initiator: FSM state encoding, default
// widths and the argument-triple record latched from the request stream.
package kernel_call_pkg;

  localparam int DEF_ARG_W = 64;
  localparam int DEF_RES_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } caller_state_t;

  // Sized for the default argument width; narrower ARG_W values use the low bits.
  typedef struct packed {
    logic [DEF_ARG_W-1:0] n;
    logic [DEF_ARG_W-1:0] a;
    logic [DEF_ARG_W-1:0] b;
  } args_t;

endpackage

// File: rtl/kernel_caller.sv
// Initiator for the kernel call protocol: request stream -> r_enable pulse ->
// wait for w_enable -> response stream. Optional WAIT timeout: KERNEL_CALLER_TIMEOUT_EN.
module kernel_caller
  import kernel_call_pkg::*;
#(
  parameter int ARG_W          = DEF_ARG_W,
  parameter int RES_W          = DEF_RES_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ARG_W-1:0] req_n,
  input  logic [ARG_W-1:0] req_a,
  input  logic [ARG_W-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [RES_W-1:0] resp_result,
  output logic             resp_timeout,
  output logic             k_r_enable,
  output logic [ARG_W-1:0] k_init_n,
  output logic [ARG_W-1:0] k_init_a,
  output logic [ARG_W-1:0] k_init_b,
  input  logic             k_w_enable,
  input  logic [RES_W-1:0] k_result,
  output logic             busy,
  output logic [CNT_W-1:0] call_count
);

  caller_state_t state, state_next;
  args_t         args_q;
  logic          expire;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign k_init_n  = args_q.n[ARG_W-1:0];
  assign k_init_a  = args_q.a[ARG_W-1:0];
  assign k_init_b  = args_q.b[ARG_W-1:0];

`ifdef KERNEL_CALLER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
  logic          timeout_q;

  // Timer holds the number of WAIT cycles already completed.
  assign expire       = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign resp_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + TW'(1);
          if (k_w_enable)  timeout_q <= 1'b0;
          else if (expire) timeout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign expire       = 1'b0;
  assign resp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next state gets its default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req_valid) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (k_w_enable || expire) state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: kernel outputs are X until its first load, so they are read only in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r_enable  <= 1'b0;
      args_q      <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      call_count  <= '0;
    end else begin
      k_r_enable <= (state == IDLE) && req_valid;
      case (state)
        IDLE: begin
          if (req_valid) begin
            args_q <= '{n: DEF_ARG_W'(req_n), a: DEF_ARG_W'(req_a), b: DEF_ARG_W'(req_b)};
          end
        end
        WAIT: begin
          if (k_w_enable) begin
            resp_result <= k_result;
            resp_valid  <= 1'b1;
          end else if (expire) begin
            resp_result <= '0;
            resp_valid  <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            call_count <= call_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_caller.sv
// Self-checking bench for kernel_caller with a behavioural fib kernel partner
// (and a stuck-busy stub mode). Timeout checks follow KERNEL_CALLER_TIMEOUT_EN.
module tb_kernel_caller;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [63:0] req_n, req_a, req_b;
  logic        resp_valid, resp_ready, resp_timeout;
  logic [63:0] resp_result;
  logic        k_r_enable, k_w_enable;
  logic [63:0] k_init_n, k_init_a, k_init_b, k_result;
  logic        busy;
  logic [15:0] call_count;

  int tests = 0;
  int fails = 0;
  int pulse_count = 0;
  int exp_count = 0;
  logic stub = 1'b0;

  kernel_caller #(
    .ARG_W(64), .RES_W(64), .TIMEOUT_CYCLES(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_timeout(resp_timeout),
    .k_r_enable(k_r_enable),
    .k_init_n(k_init_n), .k_init_a(k_init_a), .k_init_b(k_init_b),
    .k_w_enable(k_w_enable), .k_result(k_result),
    .busy(busy), .call_count(call_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fib kernel: r_enable loads and clears done; each cycle a,b <= b,a+b, n--.
  logic [63:0] kn, ka, kb, kres;
  logic        kw;
  initial begin
    kw   = 1'bx;
    kres = 'x;
  end
  always @(posedge clk) begin
    if (k_r_enable === 1'b1) begin
      kn <= k_init_n; ka <= k_init_a; kb <= k_init_b; kw <= 1'b0;
    end else if (kw === 1'b0) begin
      if (kn == 64'd0) begin
        kw   <= 1'b1;
        kres <= ka;
      end else begin
        ka <= kb; kb <= ka + kb; kn <= kn - 64'd1;
      end
    end
  end
  assign k_w_enable = stub ? 1'b0 : kw;
  assign k_result   = kres;

  always @(posedge clk) if (k_r_enable === 1'b1) pulse_count++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a request in IDLE; returns at the ISSUE-cycle negedge.
  task automatic start_req(input logic [63:0] n, a, b);
    @(negedge clk);
    req_n = n; req_a = a; req_b = b; req_valid = 1'b1;
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("issue_pulse", {63'd0, k_r_enable}, 64'd1);
    check("init_n", k_init_n, n);
    check("init_a", k_init_a, a);
    check("init_b", k_init_b, b);
  endtask

  // Step negedges after ISSUE until resp_valid; report when done and response appeared.
  task automatic wait_resp(input int max, output int wen_cyc, output int resp_cyc);
    wen_cyc  = -1;
    resp_cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (k_w_enable === 1'b1 && wen_cyc < 0) wen_cyc = i;
      if (resp_valid === 1'b1) begin
        resp_cyc = i;
        break;
      end
    end
    check("resp_arrived", {63'd0, resp_valid}, 64'd1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    exp_count++;
    check("resp_dropped", {63'd0, resp_valid}, 64'd0);
    check("call_count", {48'd0, call_count}, 64'(exp_count));
  endtask

  task automatic run_call(input logic [63:0] n, a, b, exp);
    int wc, rc;
    start_req(n, a, b);
    wait_resp(200, wc, rc);
    check("result", resp_result, exp);
    check("timeout_flag", {63'd0, resp_timeout}, 64'd0);
    check("latency", 64'(rc - wc), 64'd1);
    finish_resp();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    check({tag, "_r_enable"}, {63'd0, k_r_enable}, 64'd0);
    check({tag, "_call_count"}, {48'd0, call_count}, 64'd0);
  endtask

  typedef struct {
    logic [63:0] n, a, b, result;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int wc, rc, p0, bad;
    vecs[0] = '{n: 64'd10, a: 64'd0, b: 64'd1, result: 64'd55};
    vecs[1] = '{n: 64'd0,  a: 64'd7, b: 64'd9, result: 64'd7};
    vecs[2] = '{n: 64'd1,  a: 64'd3, b: 64'd4, result: 64'd4};
    vecs[3] = '{n: 64'd2,  a: 64'd2, b: 64'd3, result: 64'd5};
    vecs[4] = '{n: 64'd5,  a: 64'd0, b: 64'd1, result: 64'd5};
    vecs[5] = '{n: 64'd20, a: 64'd0, b: 64'd1, result: 64'd6765};

    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_n = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    check("por_result", resp_result, 64'd0);
    check("por_timeout", {63'd0, resp_timeout}, 64'd0);
    check("por_init_n", k_init_n, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      p0 = pulse_count;
      run_call(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].result);
      check("one_pulse_per_call", 64'(pulse_count - p0), 64'd1);
    end

    // Response held off for 5 cycles while another request waits.
    start_req(64'd10, 64'd0, 64'd1);
    wait_resp(200, wc, rc);
    p0 = pulse_count;
    req_n = 64'd3; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_result", resp_result, 64'd55);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    check("hold_no_pulse", 64'(pulse_count - p0), 64'd0);
    req_valid = 1'b0;
    finish_resp();

    // Back-to-back with req_valid held high and resp_ready high.
    p0 = pulse_count;
    @(negedge clk);
    req_n = 64'd10; req_a = 64'd0; req_b = 64'd1; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_n = 64'd20;
    wait_resp(200, wc, rc);
    check("b2b_first", resp_result, 64'd55);
    check("b2b_pulses_1", 64'(pulse_count - p0), 64'd1);
    @(negedge clk);
    check("b2b_idle", {63'd0, req_ready}, 64'd1);
    check("b2b_pulses_still_1", 64'(pulse_count - p0), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_issue", {63'd0, k_r_enable}, 64'd1);
    check("b2b_init_n", k_init_n, 64'd20);
    wait_resp(200, wc, rc);
    check("b2b_second", resp_result, 64'd6765);
    @(negedge clk);
    resp_ready = 1'b0;
    exp_count += 2;
    check("b2b_count", {48'd0, call_count}, 64'(exp_count));

    // Reset while waiting on the kernel.
    start_req(64'd20, 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    p0 = pulse_count;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_wait");
    check("rst_wait_no_pulse", 64'(pulse_count - p0), 64'd0);
    rst = 1'b0;
    exp_count = 0;

    // Reset while a response is pending.
    start_req(64'd3, 64'd0, 64'd1);
    wait_resp(200, wc, rc);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_resp");
    rst = 1'b0;
    exp_count = 0;
    run_call(64'd5, 64'd0, 64'd1, 64'd5);

    // Kernel that never finishes.
    stub = 1'b1;
    start_req(64'd3, 64'd0, 64'd1);
`ifdef KERNEL_CALLER_TIMEOUT_EN
    wait_resp(100, wc, rc);
    check("to_wait_cycles", 64'(rc - 1), 64'd16);
    check("to_flag", {63'd0, resp_timeout}, 64'd1);
    check("to_result", resp_result, 64'd0);
    finish_resp();
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || resp_valid !== 1'b0 || resp_timeout !== 1'b0) bad++;
    end
    check("stuck_wait_cycles_bad", 64'(bad), 64'd0);
    check("stuck_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
`endif
    stub = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
